// File: rtl/line_buffer_controller_pkg.sv
// line_buffer_controller_pkg: shared state encoding, default geometry and row-index helper
package line_buffer_controller_pkg;
    localparam int DEF_FIFO_ADDR_WIDTH      = 4;
    localparam int DEF_FIFO_DATA_WIDTH      = 8;
    localparam int DEF_FIFO_COMPONENT_COUNT = 6;
    localparam int DEF_FRAME_WIDTH          = 10;
    localparam int DEF_FRAME_HEIGHT         = 10;
    localparam int COORD_WIDTH              = 16;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} lbc_state_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 == n) ? 0 : v + 1;
    endfunction
endpackage

// File: rtl/line_buffer_controller_if.sv
// line_buffer_controller_if: pixel handshake and row-buffer control bundle
interface line_buffer_controller_if
    import line_buffer_controller_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH      = DEF_FIFO_ADDR_WIDTH,
    parameter int FIFO_DATA_WIDTH      = DEF_FIFO_DATA_WIDTH,
    parameter int FIFO_COMPONENT_COUNT = DEF_FIFO_COMPONENT_COUNT
);
    logic                                    i_start;
    logic                                    i_pixel_valid;
    logic [FIFO_DATA_WIDTH-1:0]              i_pixel;
    logic                                    o_ready;
    logic [FIFO_COMPONENT_COUNT-1:0]         o_row_wr_en;
    logic [FIFO_COMPONENT_COUNT-1:0]         o_row_rd_en;
    logic [FIFO_ADDR_WIDTH-1:0]              o_addr;
    logic [FIFO_DATA_WIDTH-1:0]              o_wr_data;
    logic [$clog2(FIFO_COMPONENT_COUNT)-1:0] o_top_row;
    logic [COORD_WIDTH-1:0]                  o_xcoord;
    logic [COORD_WIDTH-1:0]                  o_ycoord;
    logic                                    o_window_valid;
    logic                                    o_frame_done;

    modport master (
        output i_start, i_pixel_valid, i_pixel,
        input  o_ready, o_row_wr_en, o_row_rd_en, o_addr, o_wr_data, o_top_row,
               o_xcoord, o_ycoord, o_window_valid, o_frame_done
    );

    modport slave (
        input  i_start, i_pixel_valid, i_pixel,
        output o_ready, o_row_wr_en, o_row_rd_en, o_addr, o_wr_data, o_top_row,
               o_xcoord, o_ycoord, o_window_valid, o_frame_done
    );
endinterface

// File: rtl/line_buffer_controller_frame_coord_counter.sv
// frame_coord_counter: column/line counters and circular write-row index
module frame_coord_counter
    import line_buffer_controller_pkg::*;
#(
    parameter int X_WIDTH     = DEF_FIFO_ADDR_WIDTH,
    parameter int ROWS        = DEF_FIFO_COMPONENT_COUNT,
    parameter int FRAME_WIDTH = DEF_FRAME_WIDTH,
    parameter int ROW_WIDTH   = $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   advance,
    output logic [X_WIDTH-1:0]     x,
    output logic [COORD_WIDTH-1:0] y,
    output logic [ROW_WIDTH-1:0]   wr_row,
    output logic                   line_end
);
    logic [X_WIDTH-1:0]     x_q, x_d;
    logic [COORD_WIDTH-1:0] y_q, y_d;
    logic [ROW_WIDTH-1:0]   wr_row_q, wr_row_d;
    logic                   wrap;

    assign line_end = x_q == X_WIDTH'(FRAME_WIDTH - 1);
    assign wrap     = advance && line_end;
    assign x        = x_q;
    assign y        = y_q;
    assign wr_row   = wr_row_q;

    always_comb begin
        x_d      = clear ? '0 : advance ? (line_end ? '0 : x_q + 1'b1) : x_q;
        y_d      = clear ? '0 : wrap ? y_q + 1'b1 : y_q;
        wr_row_d = clear ? '0 : wrap ? ROW_WIDTH'(wrap_inc(32'(wr_row_q), ROWS)) : wr_row_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            wr_row_q <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            wr_row_q <= wr_row_d;
        end
endmodule

// File: rtl/line_buffer_controller.sv
// line_buffer_controller: sequences pixel writes/reads over a ring of row buffers and flags full windows
module line_buffer_controller
    import line_buffer_controller_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH      = DEF_FIFO_ADDR_WIDTH,
    parameter int FIFO_DATA_WIDTH      = DEF_FIFO_DATA_WIDTH,
    parameter int FIFO_COMPONENT_COUNT = DEF_FIFO_COMPONENT_COUNT,
    parameter int FRAME_WIDTH          = DEF_FRAME_WIDTH,
    parameter int FRAME_HEIGHT         = DEF_FRAME_HEIGHT
) (
    input logic                     clk,
    input logic                     reset_n,
    line_buffer_controller_if.slave bus
);
    localparam int RW = $clog2(FIFO_COMPONENT_COUNT);

    lbc_state_t                      state_q, state_d;
    logic                            ready_q, ready_d;
    logic [FIFO_COMPONENT_COUNT-1:0] wr_en_q, wr_en_d;
    logic [FIFO_COMPONENT_COUNT-1:0] rd_en_q, rd_en_d;
    logic [FIFO_ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [FIFO_DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic [RW-1:0]                   top_row_q, top_row_d;
    logic [COORD_WIDTH-1:0]          xcoord_q, xcoord_d;
    logic [COORD_WIDTH-1:0]          ycoord_q, ycoord_d;
    logic                            window_valid_q, window_valid_d;
    logic                            frame_done_q, frame_done_d;

    logic [FIFO_ADDR_WIDTH-1:0]      x;
    logic [COORD_WIDTH-1:0]          y;
    logic [RW-1:0]                   wr_row;
    logic                            line_end;
    logic                            start, accept, last, streaming, filled;
    logic [FIFO_COMPONENT_COUNT-1:0] row_oh;

    assign start     = bus.i_start && state_q == IDLE;
    assign accept    = bus.i_pixel_valid && ready_q;
    assign last      = line_end && y == COORD_WIDTH'(FRAME_HEIGHT - 1);
    assign streaming = state_q == STREAM;
    assign filled    = y >= COORD_WIDTH'(FIFO_COMPONENT_COUNT - 1);
    assign row_oh    = FIFO_COMPONENT_COUNT'(1) << wr_row;

    frame_coord_counter #(
        .X_WIDTH    (FIFO_ADDR_WIDTH),
        .ROWS       (FIFO_COMPONENT_COUNT),
        .FRAME_WIDTH(FRAME_WIDTH),
        .ROW_WIDTH  (RW)
    ) u_coord (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start),
        .advance (accept),
        .x       (x),
        .y       (y),
        .wr_row  (wr_row),
        .line_end(line_end)
    );

    // STREAM begins with the pixel after the wrap into the last fill line, since the state is sampled per pixel
    always_comb begin
        state_d        = start ? FILL :
                         state_q == DONE ? IDLE :
                         !accept ? state_q :
                         last ? DONE :
                         (state_q == FILL && line_end && y == COORD_WIDTH'(FIFO_COMPONENT_COUNT - 2)) ? STREAM :
                         state_q;
        ready_d        = state_d == FILL || state_d == STREAM;
        wr_en_d        = accept ? row_oh : '0;
        rd_en_d        = (accept && streaming) ? ~row_oh : '0;
        addr_d         = accept ? x : addr_q;
        wr_data_d      = accept ? bus.i_pixel : wr_data_q;
        xcoord_d       = accept ? COORD_WIDTH'(x) : xcoord_q;
        ycoord_d       = accept ? y : ycoord_q;
        top_row_d      = start ? '0 : !accept ? top_row_q :
                         filled ? RW'(wrap_inc(32'(wr_row), FIFO_COMPONENT_COUNT)) : '0;
        window_valid_d = accept && streaming && 32'(x) >= FIFO_COMPONENT_COUNT - 1;
        frame_done_d   = accept && last;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q        <= IDLE;
            ready_q        <= 1'b0;
            wr_en_q        <= '0;
            rd_en_q        <= '0;
            addr_q         <= '0;
            wr_data_q      <= '0;
            top_row_q      <= '0;
            xcoord_q       <= '0;
            ycoord_q       <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            ready_q        <= ready_d;
            wr_en_q        <= wr_en_d;
            rd_en_q        <= rd_en_d;
            addr_q         <= addr_d;
            wr_data_q      <= wr_data_d;
            top_row_q      <= top_row_d;
            xcoord_q       <= xcoord_d;
            ycoord_q       <= ycoord_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
        end

    assign bus.o_ready        = ready_q;
    assign bus.o_row_wr_en    = wr_en_q;
    assign bus.o_row_rd_en    = rd_en_q;
    assign bus.o_addr         = addr_q;
    assign bus.o_wr_data      = wr_data_q;
    assign bus.o_top_row      = top_row_q;
    assign bus.o_xcoord       = xcoord_q;
    assign bus.o_ycoord       = ycoord_q;
    assign bus.o_window_valid = window_valid_q;
    assign bus.o_frame_done   = frame_done_q;
endmodule
